// File: rtl/mem_bridge_pkg.sv
// Shared CPU defines for the memory bridge: FSM encoding, strobe constants
// and the latched memory request bundle.
package mem_bridge_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_I_ADDR = 3'd1;
    localparam logic [2:0] S_I_WAIT = 3'd2;
    localparam logic [2:0] S_D_ADDR = 3'd3;
    localparam logic [2:0] S_D_WAIT = 3'd4;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;
    localparam logic [3:0] WSTRB_WORD = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wr;
    } mem_req_t;

    function automatic logic is_write(input logic [3:0] wstrb);
        return wstrb != WSTRB_NONE;
    endfunction

endpackage

// File: rtl/mem_bridge.sv
// Arbitrates the CPU fetch and load/store ports onto one memory port,
// one outstanding transaction at a time, data port first.
import mem_bridge_pkg::*;

module mem_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_valid,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_valid,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    logic [2:0] r_state;
    logic [2:0] w_next;
    mem_req_t   r_req;
    logic       r_inst_done;
    logic       r_data_done;
    logic       w_data_sel;
    logic       w_inst_sel;
    logic       w_inst_done_eff;
    logic       w_data_done_eff;

    // Data is older than the fetch in program order, so it wins ties.
    assign w_data_sel = data_req & ~r_data_done;
    assign w_inst_sel = inst_req & ~r_inst_done & ~w_data_sel;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_data_sel)
                    w_next = S_D_ADDR;
                else if (w_inst_sel)
                    w_next = S_I_ADDR;
            end
            S_I_ADDR: if (mem_addr_ok) w_next = S_I_WAIT;
            S_D_ADDR: if (mem_addr_ok) w_next = S_D_WAIT;
            S_I_WAIT: if (mem_data_ok) w_next = S_IDLE;
            S_D_WAIT: if (mem_data_ok) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_data_sel) begin
                r_req.addr  <= data_addr;
                r_req.wdata <= data_wdata;
                r_req.wstrb <= data_wen;
                r_req.wr    <= is_write(data_wen);
            end else if (w_inst_sel) begin
                r_req.addr  <= inst_addr;
                r_req.wdata <= 32'd0;
                r_req.wstrb <= WSTRB_NONE;
                r_req.wr    <= 1'b0;
            end
        end
    end

    assign inst_valid = (r_state == S_I_WAIT) & mem_data_ok;
    assign data_valid = (r_state == S_D_WAIT) & mem_data_ok;
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    assign w_inst_done_eff = r_inst_done | inst_valid;
    assign w_data_done_eff = r_data_done | data_valid;

    assign cpu_stall = ~rst &
                       ((inst_req & ~w_inst_done_eff) |
                        (data_req & ~w_data_done_eff));

    // Done flags keep a finished port from re-issuing while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
        end else if (cpu_stall) begin
            r_inst_done <= w_inst_done_eff;
            r_data_done <= w_data_done_eff;
        end else begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
        end
    end

    assign mem_req   = (r_state == S_I_ADDR) | (r_state == S_D_ADDR);
    assign mem_wr    = r_req.wr;
    assign mem_wstrb = r_req.wstrb;
    assign mem_addr  = r_req.addr;
    assign mem_wdata = r_req.wdata;

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL: inst_req  in  1  CPU fetch request, held stable until the fetch is complete.
REQ-004 SHALL: inst_addr  in  32  fetch address (pcF).
REQ-005 SHALL: inst_rdata  out  32  fetched word; valid only while inst_valid=1.
REQ-006 SHALL: inst_valid  out  1  one-cycle fetch completion pulse.
REQ-007 SHALL: data_req  in  1  CPU load/store request, held stable until the access is complete.
REQ-008 SHALL: data_wen  in  4  byte write strobes; 0000 means load.
REQ-009 SHALL: data_addr  in  32  load/store address (aluoutM).
REQ-010 SHALL: data_wdata  in  32  store data.
REQ-011 SHALL: data_rdata  out  32  load word; valid only while data_valid=1.
REQ-012 SHALL: data_valid  out  1  one-cycle load/store completion pulse.
REQ-013 SHALL: cpu_stall  out  1  freeze the whole pipeline while any presented request is unfinished.
REQ-014 SHALL: mem_req  out  1  memory-side request.
REQ-015 SHALL: mem_wr  out  1  1=write, 0=read.
REQ-016 SHALL: mem_wstrb  out  4  write byte strobes.
REQ-017 SHALL: mem_addr  out  32  memory address.
REQ-018 SHALL: mem_wdata  out  32  memory write data.
REQ-019 SHALL: mem_addr_ok  in  1  memory accepts the request when mem_req and mem_addr_ok are both 1.
REQ-020 SHALL: mem_data_ok  in  1  completion of the accepted request; mem_rdata is valid in that cycle.
REQ-021 SHALL: mem_rdata  in  32  memory read data.

Function
REQ-022 SHALL: FSM states are IDLE, I_ADDR, I_WAIT, D_ADDR and D_WAIT; at most one memory transaction is outstanding.
REQ-023 SHALL: IDLE selects a port that is requesting and not done. When both qualify, data wins because it belongs to the older instruction.
REQ-024 SHALL: on entering x_ADDR, latch the address, strobes, write flag and wdata. mem_req=1 drives the latched values, which stay stable until the handshake.
REQ-025 SHALL: move x_ADDR->x_WAIT on mem_addr_ok=1 and drop mem_req in the cycle after acceptance.
REQ-026 SHALL: in x_WAIT with mem_data_ok=1, pulse x_valid in the same cycle, pass mem_rdata combinationally to x_rdata, and return to IDLE.
REQ-027 SHALL: mem_data_ok and mem_addr_ok arriving in the same cycle as the request is a legal case; ADDR->WAIT->IDLE then takes a minimum of 2 cycles.
REQ-028 SHALL: per-port done flags are set by that port's valid pulse while cpu_stall remains 1, and cleared in the cycle cpu_stall falls to 0.
REQ-029 SHALL: cpu_stall = (inst_req & ~inst_done_eff) | (data_req & ~data_done_eff), where done_eff = done flag OR this cycle's valid pulse.
REQ-030 SHALL: a completed port is never re-issued while the pipeline is frozen.
REQ-031 SHALL: a write returns data_valid on mem_data_ok. data_rdata is don't-care for writes.
REQ-032 SHALL: with no request in IDLE, outputs are mem_req=0 and cpu_stall=0.
REQ-033 SHALL: dropping a request mid-transaction is a protocol violation; the bridge still completes the memory transaction and suppresses no pulse.

Reset
REQ-034 SHALL: asserting rst forces IDLE asynchronously and clears both done flags and all latched request registers to 0.
REQ-035 SHALL: during rst, mem_req=0, inst_valid=0, data_valid=0 and cpu_stall=0.
REQ-036 SHALL: rst mid-transaction abandons the transaction; any late mem_data_ok after rst deasserts is ignored while in IDLE.

Structure
REQ-037 SHALL: the FSM state encoding (3-bit) and the constants WSTRB_NONE=4'b0000 and WSTRB_WORD=4'b1111 live in the shared CPU defines package.
REQ-038 SHALL: the block is a single flat module with no sub-modules; it is instantiated in the CPU top between the core SRAM-style ports and the memory.

Verification
REQ-039 SHALL: fetch only, inst_addr=0xBFC00000, mem_addr_ok=1 immediately, mem_data_ok after 3 cycles with mem_rdata=0x24080001 -> inst_valid 1 cycle, inst_rdata=0x24080001, cpu_stall low in the next cycle.
REQ-040 SHALL: fetch and store in the same cycle (data_addr=0x80000010, wen=1111, wdata=0xDEADBEEF) -> the write issues first, then the fetch; cpu_stall falls only after inst_valid; each address appears on mem_addr exactly once.
REQ-041 SHALL: byte store with wen=0100 -> mem_wr=1 and mem_wstrb=0100 held stable through 4 cycles of mem_addr_ok=0.
REQ-042 SHALL: load with mem_addr_ok and mem_data_ok both 1 in the issue cycle -> data_valid appears 2 cycles after data_req rises, carrying mem_rdata.
REQ-043 SHALL: rst pulse while in I_WAIT, followed by a stray mem_data_ok -> FSM in IDLE, no inst_valid, mem_req=0.
REQ-044 SHALL: back-to-back fetches 0x0, 0x4 and 0x8 with a 1-cycle memory -> three inst_valid pulses with no duplicate mem_addr.
